seg7_scan_driver: RTL and testbench

//  Parametrised multiplexed 7-segment driver. Time-multiplexes NUM_DIGITS digits with a
//  per-digit blank mask, PWM brightness, anti-ghost blanking and tear-free frame-synchronous

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/seg7_prescaler.sv | 31 +++
 rtl/seg7_scan_driver.sv | 122 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns and helpers for the 7-segment scan driver.
// Bit order is {dp,g,f,e,d,c,b,a}, 1 = segment lit.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'h00;
    localparam logic [7:0] SEG_0      = 8'h3F;
    localparam logic [7:0] SEG_1      = 8'h06;
    localparam logic [7:0] SEG_2      = 8'h5B;
    localparam logic [7:0] SEG_3      = 8'h4F;
    localparam logic [7:0] SEG_4      = 8'h66;
    localparam logic [7:0] SEG_5      = 8'h6D;
    localparam logic [7:0] SEG_6      = 8'h7D;
    localparam logic [7:0] SEG_7      = 8'h07;
    localparam logic [7:0] SEG_8      = 8'h7F;
    localparam logic [7:0] SEG_9      = 8'h6F;
    localparam logic [7:0] SEG_HEX_A  = 8'h77;
    localparam logic [7:0] SEG_HEX_B  = 8'h7C;
    localparam logic [7:0] SEG_HEX_C  = 8'h39;
    localparam logic [7:0] SEG_HEX_D  = 8'h5E;
    localparam logic [7:0] SEG_HEX_E  = 8'h79;
    localparam logic [7:0] SEG_HEX_F  = 8'h71;
    localparam logic [7:0] SEG_NOTE_C = 8'h39;
    localparam logic [7:0] SEG_NOTE_D = 8'h5E;
    localparam logic [7:0] SEG_NOTE_E = 8'h79;
    localparam logic [7:0] SEG_NOTE_F = 8'h71;
    localparam logic [7:0] SEG_NOTE_G = 8'h3D;
    localparam logic [7:0] SEG_NOTE_A = 8'h77;
    localparam logic [7:0] SEG_NOTE_B = 8'h7C;
    localparam logic [7:0] SEG_SHARP  = 8'h80;

    function automatic logic [7:0] seg7_hex(input logic [3:0] nibble);
        logic [7:0] p;
        case (nibble)
            4'h0: p = SEG_0;
            4'h1: p = SEG_1;
            4'h2: p = SEG_2;
            4'h3: p = SEG_3;
            4'h4: p = SEG_4;
            4'h5: p = SEG_5;
            4'h6: p = SEG_6;
            4'h7: p = SEG_7;
            4'h8: p = SEG_8;
            4'h9: p = SEG_9;
            4'hA: p = SEG_HEX_A;
            4'hB: p = SEG_HEX_B;
            4'hC: p = SEG_HEX_C;
            4'hD: p = SEG_HEX_D;
            4'hE: p = SEG_HEX_E;
            default: p = SEG_HEX_F;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running divide-by-DIV counter with a strobe on its last count.
// Sets the length of one PWM phase inside a digit slot.
module seg7_prescaler #(
    parameter int DIV = 4,
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] pre_o,
    output logic         wrap_o
);

    logic [W-1:0] pre_q;
    logic [W-1:0] pre_d;
    logic         wrap;

    assign wrap = (pre_q == W'(DIV - 1));

    always_comb begin
        pre_d = wrap ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

    assign pre_o  = pre_q;
    assign wrap_o = wrap;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with PWM dimming, anti-ghost blank
// cycle and frame-synchronous commit of new segment patterns.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_CYC   = 200000,
    parameter int PWM_BITS   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*NUM_DIGITS-1:0] seg_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic                    load_ack,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg
);

    localparam int PRE_DIV = SLOT_CYC >> PWM_BITS;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW      = 8 * NUM_DIGITS;

    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW != 0}};
    localparam logic [7:0]            SEG_POL = {8{ACTIVE_LOW != 0}};

    logic [PRE_W-1:0]      pre;
    logic                  pre_wrap;
    logic                  phase_wrap;
    logic                  frame_wrap;
    logic                  digit_on;

    logic [PWM_BITS-1:0]   phase_q, phase_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         staging_q, staging_d;
    logic [DW-1:0]         display_q, display_d;
    logic                  pending_q, pending_d;
    logic                  ack_q, ack_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;

    seg7_prescaler #(.DIV(PRE_DIV)) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .pre_o  (pre),
        .wrap_o (pre_wrap)
    );

    assign phase_wrap = pre_wrap && (phase_q == '1);
    assign frame_wrap = phase_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        phase_d = pre_wrap ? phase_q + 1'b1 : phase_q;
        idx_d   = idx_q;
        if (phase_wrap) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // A load on the boundary cycle itself bypasses staging straight to display.
    always_comb begin
        staging_d = staging_q;
        display_d = display_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (load) begin
            staging_d = seg_data;
            pending_d = 1'b1;
        end
        if (frame_wrap && (pending_q || load)) begin
            display_d = load ? seg_data : staging_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
    end

    // First cycle of every slot is forced dark to hide anode switching ghosts.
    assign digit_on = digit_en[idx_q]
                   && (phase_q <= brightness)
                   && !((phase_q == '0) && (pre == '0));

    always_comb begin
        an_d  = AN_POL;
        seg_d = SEG_BLANK ^ SEG_POL;
        if (digit_on) begin
            an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_POL;
            seg_d = display_q[8*idx_q +: 8] ^ SEG_POL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= '0;
            idx_q     <= '0;
            staging_q <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            an_q      <= AN_POL;
            seg_q     <= SEG_BLANK ^ SEG_POL;
        end else begin
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            staging_q <= staging_d;
            display_q <= display_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign load_ack   = ack_q;
    assign frame_done = frame_wrap;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4-digit active-low instance
// plus a 1-digit active-high instance on the same clock and reset.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] seg_data = '0;
    logic [3:0]  digit_en = 4'hF;
    logic        load = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic        load_ack, frame_done;
    logic [3:0]  an;
    logic [7:0]  seg;

    logic [7:0]  seg_data1 = 8'h3F;
    logic [0:0]  digit_en1 = 1'b1;
    logic        load1 = 1'b0;
    logic [1:0]  brightness1 = 2'd3;
    logic        load_ack1, frame_done1;
    logic [0:0]  an1;
    logic [7:0]  seg1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int cnt[4];
    int fdc;
    int a0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SLOT_CYC(16), .PWM_BITS(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seg_data(seg_data),
        .digit_en(digit_en), .load(load), .brightness(brightness),
        .load_ack(load_ack), .frame_done(frame_done), .an(an), .seg(seg)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(1), .SLOT_CYC(16), .PWM_BITS(2), .ACTIVE_LOW(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .seg_data(seg_data1),
        .digit_en(digit_en1), .load(load1), .brightness(brightness1),
        .load_ack(load_ack1), .frame_done(frame_done1), .an(an1), .seg(seg1)
    );

    // cyc = number of rising edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (load_ack === 1'b1) ack_cnt = ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic goto(input int k);
        int guard = 0;
        while (cyc < k && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < k) chk("goto_timeout", cyc, k);
    endtask

    task automatic scan_frame(input int start);
        logic [3:0] pat;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        fdc = 0;
        for (int s = start; s < start + 64; s++) begin
            goto(s);
            for (int k = 0; k < 4; k++) begin
                pat = ~(4'b0001 << k);
                if (an === pat) cnt[k]++;
            end
            if (frame_done === 1'b1) fdc++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_ack", load_ack, 1'b0);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_an1", an1, 1'b0);
        rst_n = 1'b1;

        goto(1);  chk("blank_c1", an, 4'b1111);
        chk("an1_c1", an1, 1'b0);
        goto(2);  chk("first_on", an, 4'b1110);
        chk("first_seg", seg, 8'hFF);
        chk("an1_c2", an1, 1'b1);
        goto(15); chk("fd1_15", frame_done1, 1'b1);
        goto(16); chk("fd1_16", frame_done1, 1'b0);
        goto(17); chk("an1_blank", an1, 1'b0);
        goto(18); chk("scan_d1", an, 4'b1101);
        chk("an1_on", an1, 1'b1);
        goto(31); chk("fd1_31", frame_done1, 1'b1);
        goto(34); chk("scan_d2", an, 4'b1011);
        goto(50); chk("scan_d3", an, 4'b0111);
        goto(62); chk("fd_62", frame_done, 1'b0);
        goto(63); chk("fd_63", frame_done, 1'b1);
        goto(66); chk("scan_wrap", an, 4'b1110);

        goto(70); seg_data = 32'hC0F9A4B0; load = 1'b1;
        goto(71); load = 1'b0;
        goto(76); chk("hold_seg", seg, 8'hFF);
        chk("hold_an", an, 4'b1110);
        goto(127); chk("ack_pre", load_ack, 1'b0);
        chk("fd_127", frame_done, 1'b1);
        goto(128); chk("ack_on", load_ack, 1'b1);
        goto(129); chk("ack_off", load_ack, 1'b0);
        goto(130); chk("d0_an", an, 4'b1110);
        chk("d0_seg", seg, 8'h4F);
        goto(178); chk("d3_an", an, 4'b0111);
        chk("d3_seg", seg, 8'h3F);

        goto(200); a0 = ack_cnt;
        seg_data = 32'h11223344; load = 1'b1;
        goto(201); load = 1'b0;
        goto(210); seg_data = 32'h065B4F66; load = 1'b1;
        goto(211); load = 1'b0;
        chk("dbl_noack", load_ack, 1'b0);
        goto(256); chk("dbl_ack", load_ack, 1'b1);
        goto(258); chk("dbl_seg", seg, 8'h99);
        goto(300); chk("dbl_once", ack_cnt - a0, 1);

        goto(319); seg_data = 32'h0000007F; load = 1'b1;
        goto(320); load = 1'b0;
        chk("byp_ack", load_ack, 1'b1);
        goto(322); chk("byp_seg", seg, 8'h80);
        chk("byp_an", an, 4'b1110);

        goto(330); brightness = 2'd0;
        scan_frame(385);
        chk("br0_d0", cnt[0], 3);
        chk("br0_d2", cnt[2], 3);
        goto(460); brightness = 2'd1;
        scan_frame(513);
        chk("br1_d1", cnt[1], 7);
        chk("br1_d3", cnt[3], 7);
        goto(600); brightness = 2'd3;
        scan_frame(641);
        chk("br3_d0", cnt[0], 15);
        chk("br3_fd", fdc, 1);

        goto(710); digit_en = 4'b0101;
        scan_frame(769);
        chk("mask_d0", cnt[0], 15);
        chk("mask_d1", cnt[1], 0);
        chk("mask_d2", cnt[2], 15);
        chk("mask_d3", cnt[3], 0);
        chk("mask_fd", fdc, 1);

        goto(850); digit_en = 4'hF;
        seg_data = 32'hFFFFFFFF; load = 1'b1;
        goto(851); load = 1'b0;
        goto(855); rst_n = 1'b0;
        #1;
        chk("mid_rst_an", an, 4'b1111);
        chk("mid_rst_seg", seg, 8'hFF);
        chk("mid_rst_fd", frame_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        a0 = ack_cnt;
        goto(2); chk("post_an", an, 4'b1110);
        chk("post_seg", seg, 8'hFF);
        goto(70); chk("lost_ack", ack_cnt - a0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
